// File: rtl/zeroriscy_vector_store_unit.sv
// Vector store unit: snapshots one vector register and writes its lanes to data
// memory as sequential single-word stores over the req/gnt/rvalid protocol.
module zeroriscy_vector_store_unit #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int VREG_AW    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  output logic                            ready_o,
  input  logic [VREG_AW-1:0]              vreg_addr_i,
  input  logic [ADDR_WIDTH-1:0]           base_addr_i,
  input  logic [ADDR_WIDTH-1:0]           stride_i,
  output logic [VREG_AW-1:0]              vrf_raddr_o,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] vrf_rdata_i,
  output logic                            data_req_o,
  input  logic                            data_gnt_i,
  input  logic                            data_rvalid_i,
  input  logic                            data_err_i,
  output logic [ADDR_WIDTH-1:0]           data_addr_o,
  output logic                            data_we_o,
  output logic [3:0]                      data_be_o,
  output logic [DATA_WIDTH-1:0]           data_wdata_o,
  output logic                            done_o,
  output logic                            err_o
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SNAP = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            r_state;
  logic [VREG_AW-1:0]    r_vreg;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LANE_W-1:0]     r_lane;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_buf [NUM_LANES];

  logic w_in_req;
  logic w_misaligned;
  logic w_last_lane;

  assign w_in_req     = (r_state == S_REQ);
  assign w_misaligned = (base_addr_i[1:0] != 2'b00) || (stride_i[1:0] != 2'b00);
  assign w_last_lane  = (r_lane == LANE_W'(NUM_LANES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_vreg   <= '0;
      r_base   <= '0;
      r_stride <= '0;
      r_addr   <= '0;
      r_lane   <= '0;
      r_err    <= 1'b0;
      for (int unsigned i = 0; i < NUM_LANES; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_vreg   <= vreg_addr_i;
            r_base   <= base_addr_i;
            r_stride <= stride_i;
            r_err    <= w_misaligned;
            r_state  <= w_misaligned ? S_DONE : S_SNAP;
          end
        end
        S_SNAP: begin
          // Private copy decouples the store from later register-file writes.
          for (int unsigned i = 0; i < NUM_LANES; i++)
            r_buf[i] <= vrf_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
          r_lane  <= '0;
          r_addr  <= r_base;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (data_gnt_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (data_rvalid_i) begin
            if (data_err_i) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else if (w_last_lane) begin
              r_state <= S_DONE;
            end else begin
              r_lane  <= r_lane + LANE_W'(1);
              r_addr  <= r_addr + r_stride;
              r_state <= S_REQ;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o      = (r_state == S_IDLE);
  assign vrf_raddr_o  = (r_state == S_SNAP) ? r_vreg : '0;
  assign data_req_o   = w_in_req;
  assign data_we_o    = w_in_req;
  assign data_be_o    = w_in_req ? 4'hF : 4'h0;
  assign data_addr_o  = w_in_req ? r_addr : '0;
  assign data_wdata_o = w_in_req ? r_buf[r_lane] : '0;
  assign done_o       = (r_state == S_DONE);
  assign err_o        = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_zeroriscy_vector_store_unit.sv
// Self-checking bench: table-driven directed commands, a reset-abort sequence and
// randomized commands checked against a store-list / cycle-count reference model.
module tb_zeroriscy_vector_store_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         ready_o;
  logic [3:0]   vreg_addr_i;
  logic [31:0]  base_addr_i;
  logic [31:0]  stride_i;
  logic [3:0]   vrf_raddr_o;
  logic [127:0] vrf_rdata_i;
  logic         data_req_o;
  logic         data_gnt_i;
  logic         data_rvalid_i;
  logic         data_err_i;
  logic [31:0]  data_addr_o;
  logic         data_we_o;
  logic [3:0]   data_be_o;
  logic [31:0]  data_wdata_o;
  logic         done_o;
  logic         err_o;

  zeroriscy_vector_store_unit #(
    .NUM_LANES(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .VREG_AW(4)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ready_o(ready_o),
    .vreg_addr_i(vreg_addr_i), .base_addr_i(base_addr_i), .stride_i(stride_i),
    .vrf_raddr_o(vrf_raddr_o), .vrf_rdata_i(vrf_rdata_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Register-file model with combinational read.
  logic [31:0] vrf [16][4];
  always_comb begin
    vrf_rdata_i = '0;
    for (int k = 0; k < 4; k++) vrf_rdata_i[k*32 +: 32] = vrf[vrf_raddr_o][k];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cfg [4];
  bit noise = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit misaligned(input logic [31:0] base, input logic [31:0] stride);
    return (base[1:0] != 2'b00) || (stride[1:0] != 2'b00);
  endfunction

  // Expected done cycle: SNAP is cycle 1, each issued lane costs its REQ cycles plus response delay.
  function automatic int model_done(input logic [31:0] base, input logic [31:0] stride,
                                    input int err_lane, input int rv_delay);
    int n;
    int t;
    if (misaligned(base, stride)) return 1;
    n = (err_lane >= 0 && err_lane < 4) ? err_lane + 1 : 4;
    t = 2;
    for (int k = 0; k < n; k++) t += 1 + stall_cfg[k] + rv_delay;
    return t;
  endfunction

  task automatic run_cmd(input logic [3:0] vreg, input logic [31:0] base, input logic [31:0] stride,
                         input int err_lane, input int rv_delay, input bit overwrite,
                         input bit busy_start, input int rst_lane, input int exp_done,
                         input bit exp_err, input string tag);
    logic [31:0] snap [4];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    logic [31:0] got_addr [$];
    logic [31:0] got_data [$];
    logic [31:0] req_addr;
    logic [31:0] req_data;
    int n_exp;
    int cyc;
    int lane;
    int stall_left;
    int rv_at;
    int rv_lane;
    int rst_cyc;
    int done_cyc;
    int unstable;
    int bad_be;
    bit in_req;
    bit finished;
    bit aborted;
    bit err_seen;
    bit busy_rdy;

    for (int k = 0; k < 4; k++) snap[k] = vrf[vreg][k];
    if (misaligned(base, stride)) n_exp = 0;
    else if (rst_lane >= 0) n_exp = rst_lane + 1;
    else if (err_lane >= 0 && err_lane < 4) n_exp = err_lane + 1;
    else n_exp = 4;
    for (int k = 0; k < n_exp; k++) begin
      exp_addr.push_back(base + stride * 32'(k));
      exp_data.push_back(snap[k]);
    end

    cyc = 0; lane = 0; stall_left = 0; rv_at = -1; rv_lane = -1; rst_cyc = -1;
    done_cyc = -1; unstable = 0; bad_be = 0; in_req = 0; finished = 0; aborted = 0;
    err_seen = 0; busy_rdy = 0; req_addr = '0; req_data = '0;

    @(negedge clk);
    check({tag, ".ready_idle"}, 64'(ready_o), 64'd1);
    start_i = 1'b1; vreg_addr_i = vreg; base_addr_i = base; stride_i = stride;

    while (!finished && !aborted && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({tag, ".rst_req"},   64'(data_req_o), 64'd0);
        check({tag, ".rst_ready"}, 64'(ready_o),    64'd1);
        check({tag, ".rst_done"},  64'({done_o, err_o}), 64'd0);
        for (int j = 0; j < 3; j++) begin
          data_rvalid_i = 1'b1; data_err_i = 1'b1;
          @(negedge clk);
          check({tag, ".late_rvalid"}, 64'({data_req_o, ready_o, done_o, err_o}), 64'b0100);
        end
        data_rvalid_i = 1'b0; data_err_i = 1'b0;
        aborted = 1;
      end else begin
        if (cyc == rv_at) begin
          data_rvalid_i = 1'b1;
          data_err_i = (rv_lane == err_lane);
          rv_at = -1;
        end
        if (data_req_o) begin
          if (!in_req) begin
            in_req = 1;
            got_addr.push_back(data_addr_o);
            got_data.push_back(data_wdata_o);
            req_addr = data_addr_o;
            req_data = data_wdata_o;
            stall_left = stall_cfg[lane & 3];
            if (data_be_o !== 4'hF || data_we_o !== 1'b1) bad_be++;
            if (lane == 0 && overwrite)
              for (int k = 0; k < 4; k++) vrf[vreg][k] = 32'hDEADBEEF;
            if (lane == 1 && busy_start) begin
              busy_rdy = ready_o;
              start_i = 1'b1; vreg_addr_i = 4'd5; base_addr_i = 32'h2000; stride_i = 32'd8;
            end
          end else if (data_addr_o !== req_addr || data_wdata_o !== req_data ||
                       data_be_o !== 4'hF || data_we_o !== 1'b1) begin
            unstable++;
          end
          if (stall_left == 0) begin
            data_gnt_i = 1'b1;
            in_req = 0;
            rv_at = cyc + rv_delay;
            rv_lane = lane;
            if (lane == rst_lane) rst_cyc = cyc + 1;
            lane++;
          end else begin
            stall_left--;
            if (noise && ($urandom_range(1) == 1)) begin
              data_rvalid_i = 1'b1; data_err_i = 1'b1;
            end
          end
        end else if (noise && rv_at != cyc) begin
          data_gnt_i = 1'($urandom_range(1));
        end
        if (done_o) begin
          done_cyc = cyc;
          err_seen = err_o;
          finished = 1;
        end
      end
    end

    if (!aborted) begin
      check({tag, ".done_seen"}, 64'(finished), 64'd1);
      check({tag, ".done_cycle"}, 64'(done_cyc), 64'(exp_done));
      check({tag, ".err"}, 64'(err_seen), 64'(exp_err));
      @(negedge clk);
      check({tag, ".pulse_end"}, 64'({done_o, err_o, data_req_o, ready_o}), 64'b0001);
    end
    check({tag, ".n_stores"}, 64'(got_addr.size()), 64'(n_exp));
    check({tag, ".req_stable"}, 64'(unstable), 64'd0);
    check({tag, ".be_we"}, 64'(bad_be), 64'd0);
    for (int k = 0; k < n_exp && k < got_addr.size(); k++) begin
      check($sformatf("%s.addr%0d", tag, k), 64'(got_addr[k]), 64'(exp_addr[k]));
      check($sformatf("%s.data%0d", tag, k), 64'(got_data[k]), 64'(exp_data[k]));
    end
    if (busy_start) begin
      check({tag, ".busy_ready"}, 64'(busy_rdy), 64'd0);
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        check({tag, ".busy_ignored"}, 64'({data_req_o, done_o, ready_o}), 64'b001);
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [31:0] stride;
    int          stall_lane;
    int          stall_n;
    int          err_lane;
    bit          overwrite;
    bit          busy_start;
    int          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic load_vreg3();
    vrf[3][0] = 32'h11111111; vrf[3][1] = 32'h22222222;
    vrf[3][2] = 32'h33333333; vrf[3][3] = 32'h44444444;
  endtask

  initial begin
    vecs[0] = '{"unit",     32'h1000, 32'd4,        -1, 0, -1, 0, 0, 10, 0};
    vecs[1] = '{"gstall",   32'h1000, 32'd4,         1, 3, -1, 0, 0, 13, 0};
    vecs[2] = '{"negwrap",  32'h4,    32'hFFFFFFFC, -1, 0, -1, 0, 0, 10, 0};
    vecs[3] = '{"err1",     32'h1000, 32'd4,        -1, 0,  1, 0, 0,  6, 1};
    vecs[4] = '{"misbase",  32'h1002, 32'd4,        -1, 0, -1, 0, 0,  1, 1};
    vecs[5] = '{"misstride",32'h1000, 32'd6,        -1, 0, -1, 0, 0,  1, 1};
    vecs[6] = '{"snapbusy", 32'h1000, 32'd4,        -1, 0, -1, 1, 1, 10, 0};

    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 4; k++) vrf[r][k] = {r[7:0], k[7:0], 16'hA5A5};
    rst = 1'b1; start_i = 1'b0; vreg_addr_i = '0; base_addr_i = '0; stride_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    for (int k = 0; k < 4; k++) stall_cfg[k] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset.ctrl", 64'({ready_o, data_req_o, data_we_o, done_o, err_o}), 64'b10000);
    check("reset.be", 64'(data_be_o), 64'd0);
    check("reset.addr", 64'(data_addr_o), 64'd0);
    check("reset.wdata", 64'(data_wdata_o), 64'd0);
    check("reset.raddr", 64'(vrf_raddr_o), 64'd0);

    for (int v = 0; v < 7; v++) begin
      load_vreg3();
      for (int k = 0; k < 4; k++) stall_cfg[k] = (k == vecs[v].stall_lane) ? vecs[v].stall_n : 0;
      run_cmd(4'd3, vecs[v].base, vecs[v].stride, vecs[v].err_lane, 1, vecs[v].overwrite,
              vecs[v].busy_start, -1, vecs[v].exp_done, vecs[v].exp_err, vecs[v].name);
    end

    // Reset during WAIT of lane 2, then a normal command afterwards.
    load_vreg3();
    for (int k = 0; k < 4; k++) stall_cfg[k] = 0;
    run_cmd(4'd3, 32'h1000, 32'd4, -1, 1, 0, 0, 2, 0, 0, "rstmid");
    run_cmd(4'd3, 32'h3000, 32'd16, -1, 1, 0, 0, -1, 10, 0, "afterrst");

    noise = 1'b1;
    for (int t = 0; t < 25; t++) begin
      logic [3:0]  vr;
      logic [31:0] b;
      logic [31:0] s;
      int          el;
      int          rd;
      vr = 4'($urandom_range(15));
      for (int k = 0; k < 4; k++) vrf[vr][k] = $urandom;
      b = $urandom;
      if ($urandom_range(5) != 0) b[1:0] = 2'b00;
      s = 32'($urandom_range(64)) << 2;
      if ($urandom_range(1) == 1) s = -s;
      el = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1;
      rd = int'($urandom_range(1, 3));
      for (int k = 0; k < 4; k++) stall_cfg[k] = int'($urandom_range(2));
      run_cmd(vr, b, s, el, rd, 0, 0, -1, model_done(b, s, el, rd),
              misaligned(b, s) || (el >= 0), $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
